// File: rtl/jump_concatenation_pkg.sv
// concat_pkg: shared widths, WORD_ALIGN encodings and the address type for jump_concatenation
package concat_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_IMM_W = 26;
  localparam int ALIGN_NONE = 0;
  localparam int ALIGN_WORD = 1;
  typedef logic [DEF_ADDR_W-1:0] addr_t;
endpackage

// File: rtl/jump_target_comb.sv
// jump_target_comb: combinational jump target from PC upper field and immediate
// Ports: pc (program counter), imm (jump immediate), target (joined address).
// Macro CONCAT_PC_PLUS4_EN: upper field taken from pc+4 instead of pc.
module jump_target_comb
  import concat_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IMM_W = DEF_IMM_W,
  parameter int WORD_ALIGN = ALIGN_NONE
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [IMM_W-1:0]  imm,
  output logic [ADDR_W-1:0] target
);
  localparam int SH = (WORD_ALIGN == ALIGN_WORD) ? 2 : 0;
  // Ones over every bit position the immediate (and alignment zeros) replace;
  // a shift by ADDR_W yields 0, so the mask becomes all ones in that case.
  localparam logic [ADDR_W-1:0] LOW = (ADDR_W'(1) << (IMM_W + SH)) - ADDR_W'(1);
  logic [ADDR_W-1:0] base;
  if (IMM_W >= ADDR_W) begin : g_bad_imm
    $error("jump_target_comb: IMM_W must be smaller than ADDR_W");
  end
  if (WORD_ALIGN == ALIGN_WORD && IMM_W + 2 > ADDR_W) begin : g_bad_align
    $error("jump_target_comb: IMM_W+2 exceeds ADDR_W with word alignment");
  end
`ifdef CONCAT_PC_PLUS4_EN
  assign base = pc + ADDR_W'(4);
`else
  assign base = pc;
`endif
  // Masking with AND keeps discarded PC bits from leaking X into the target.
  assign target = (base & ~LOW) | (ADDR_W'(imm) << SH);
endmodule

// File: rtl/jump_concatenation.sv
// jump_concatenation: registered jump-target concatenation with load enable and valid flag
// Ports: clk, rst_n (async active-low), en (capture), PC, Immediate26,
//        ConcatenatedResult (registered target), result_valid (high the cycle after a capture).
// Macro CONCAT_PC_PLUS4_EN: upper field from PC+4 (handled in jump_target_comb).
module jump_concatenation
  import concat_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IMM_W = DEF_IMM_W,
  parameter int WORD_ALIGN = ALIGN_NONE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] PC,
  input  logic [IMM_W-1:0]  Immediate26,
  output logic [ADDR_W-1:0] ConcatenatedResult,
  output logic              result_valid
);
  logic [ADDR_W-1:0] target;
  jump_target_comb #(.ADDR_W(ADDR_W), .IMM_W(IMM_W), .WORD_ALIGN(WORD_ALIGN)) u_target (
    .pc(PC),
    .imm(Immediate26),
    .target(target)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ConcatenatedResult <= '0;
      result_valid <= 1'b0;
    end else begin
      ConcatenatedResult <= en ? target : ConcatenatedResult;
      result_valid <= en;
    end
  end
endmodule

// File: tb/tb_jump_concatenation.sv
// tb_jump_concatenation: scoreboard bench for both WORD_ALIGN settings of jump_concatenation
module tb_jump_concatenation;
  import concat_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  addr_t pc = '0;
  logic [25:0] imm = '0;
  addr_t res0, res1;
  logic val0, val1;
  addr_t q0[$], q1[$];
  addr_t last0 = '0, last1 = '0;
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  jump_concatenation dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .PC(pc), .Immediate26(imm),
    .ConcatenatedResult(res0), .result_valid(val0)
  );
  jump_concatenation #(.WORD_ALIGN(ALIGN_WORD)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .PC(pc), .Immediate26(imm),
    .ConcatenatedResult(res1), .result_valid(val1)
  );

  function automatic addr_t model(input addr_t p, input logic [25:0] i, input bit word);
    addr_t u;
`ifdef CONCAT_PC_PLUS4_EN
    u = p + 32'd4;
`else
    u = p;
`endif
    return word ? {u[31:28], i, 2'b00} : {u[31:26], i};
  endfunction

  task automatic chk(input string tag, input addr_t got, input addr_t exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
      $error("%s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic e, input addr_t p, input logic [25:0] i);
    en = e;
    pc = p;
    imm = i;
    if (e) begin
      q0.push_back(model(p, i, 1'b0));
      q1.push_back(model(p, i, 1'b1));
    end
    @(posedge clk);
    #1;
    chk("valid0", addr_t'(val0), addr_t'(e));
    chk("valid1", addr_t'(val1), addr_t'(e));
    if (e) begin
      last0 = q0.pop_front();
      last1 = q1.pop_front();
    end
    chk(e ? "capture0" : "hold0", res0, last0);
    chk(e ? "capture1" : "hold1", res1, last1);
  endtask

  initial begin
    #2;
    chk("rst_res0", res0, '0);
    chk("rst_val0", addr_t'(val0), '0);
    chk("rst_res1", res1, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'h1234_5678, 26'h0ABCDEF);
    step(1'b1, 32'hAABB_CCDD, 26'h0123456);
`ifndef CONCAT_PC_PLUS4_EN
    chk("tp_capture1", res0, 32'hA812_3456);
    chk("tp_word1", res1, 32'hA048_D158);
`endif
    step(1'b1, 32'h1122_3344, 26'h0ABCDEF);
`ifndef CONCAT_PC_PLUS4_EN
    chk("tp_capture2", res0, 32'h10AB_CDEF);
`endif
    step(1'b0, 32'hFFFF_FFFF, 26'h3FFFFFF);
    step(1'b0, 32'h0000_0000, 26'h0000000);
    step(1'b1, 32'hFFFF_FFFF, 26'h3FFFFFF);
`ifndef CONCAT_PC_PLUS4_EN
    chk("tp_word_edge", res1, 32'hFFFF_FFFC);
`endif
    step(1'b1, 32'h0FFF_FFFC, 26'h0000001);
`ifdef CONCAT_PC_PLUS4_EN
    chk("tp_plus4", res0, 32'h1000_0001);
`else
    chk("tp_noplus4", res0, 32'h0C00_0001);
`endif
    for (int k = 0; k < 40; k++)
      step(1'($urandom_range(0, 2) != 0), addr_t'($urandom), 26'($urandom));
    step(1'b1, 32'hDEAD_BEEF, 26'h2AAAAAA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_res0", res0, '0);
    chk("midrst_val0", addr_t'(val0), '0);
    chk("midrst_res1", res1, '0);
    chk("midrst_val1", addr_t'(val1), '0);
    last0 = '0;
    last1 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'h5555_5555, 26'h1555555);
    step(1'b1, 32'h5555_5555, 26'h1555555);
    step(1'b1, 32'h8000_0000, 26'h0000000);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
